// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier:
// FSM state encoding and the iteration-counter width helper.
package mult_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Counter must hold B_WIDTH itself, so it needs one more code than B_WIDTH-1.
   function automatic int cnt_width(input int b_width);
      return $clog2(b_width + 1);
   endfunction

endpackage

// File: rtl/seq_shift_add_multiplier_if.sv
// Start/done handshake bundle between the operand source and the multiplier.
// Widths follow the multiplier's A_WIDTH/B_WIDTH; the product is their sum.
interface seq_shift_add_multiplier_if #(
   parameter int A_WIDTH = 4,
   parameter int B_WIDTH = 3
);

   logic                         start;
   logic [A_WIDTH-1:0]           a;
   logic [B_WIDTH-1:0]           b;
   logic                         busy;
   logic                         done;
   logic [A_WIDTH+B_WIDTH-1:0]   product;

   modport master (
      output start,
      output a,
      output b,
      input  busy,
      input  done,
      input  product
   );

   modport slave (
      input  start,
      input  a,
      input  b,
      output busy,
      output done,
      output product
   );

endinterface

// File: rtl/seq_shift_add_multiplier.sv
// Unsigned sequential multiplier: one multiplier bit per cycle, fixed latency of
// B_WIDTH RUN cycles followed by a single DONE cycle that pulses done.
module seq_shift_add_multiplier
   import mult_pkg::*;
#(
   parameter int A_WIDTH = 4,
   parameter int B_WIDTH = 3
) (
   input  logic                        clk,
   input  logic                        rst_n,
   seq_shift_add_multiplier_if.slave   bus
);

   localparam int P_WIDTH = A_WIDTH + B_WIDTH;
   localparam int CNT_W   = cnt_width(B_WIDTH);

   state_t              state;
   state_t              state_next;
   logic                load;
   logic                step;

   logic [P_WIDTH-1:0]  mcand;
   logic [B_WIDTH-1:0]  mplier;
   logic [P_WIDTH-1:0]  acc;
   logic [CNT_W-1:0]    cnt;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of block ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // NOTE: every output of this block gets a default first; a path that left
   // one unassigned would infer a latch.
   always_comb begin
      state_next = state;
      load       = 1'b0;
      step       = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (bus.start) begin
               load       = 1'b1;
               state_next = ST_RUN;
            end
         end
         ST_RUN: begin
            step = 1'b1;
            if (cnt == CNT_W'(1)) begin
               state_next = ST_DONE;
            end
         end
         ST_DONE: begin
            // A start here chains directly into the next operation.
            if (bus.start) begin
               load       = 1'b1;
               state_next = ST_RUN;
            end else begin
               state_next = ST_IDLE;
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // NOTE: datapath registers are plain flops (not a memory array), so all of
   // them are reset to give a deterministic product after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcand  <= '0;
         mplier <= '0;
         acc    <= '0;
         cnt    <= '0;
      end else if (load) begin
         mcand  <= P_WIDTH'(bus.a);
         mplier <= bus.b;
         acc    <= '0;
         cnt    <= CNT_W'(B_WIDTH);
      end else if (step) begin
         if (mplier[0]) begin
            acc <= acc + mcand;
         end
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         cnt    <= cnt - CNT_W'(1);
      end
   end

   assign bus.busy    = (state == ST_RUN);
   assign bus.done    = (state == ST_DONE);
   assign bus.product = acc;

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Directed bench for seq_shift_add_multiplier: reset, single op, exhaustive 4x3
// back-to-back, start-while-busy, reset abort and an 8x8 parameter override.
module tb_seq_shift_add_multiplier;

   logic clk;
   logic rst_n;

   int checks;
   int errors;

   seq_shift_add_multiplier_if #(.A_WIDTH(4), .B_WIDTH(3)) bus ();
   seq_shift_add_multiplier_if #(.A_WIDTH(8), .B_WIDTH(8)) wbus ();

   seq_shift_add_multiplier #(.A_WIDTH(4), .B_WIDTH(3)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   seq_shift_add_multiplier #(.A_WIDTH(8), .B_WIDTH(8)) dut_wide (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (wbus.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic test_reset();
      rst_n     = 1'b0;
      bus.start = 1'b1;
      bus.a     = 4'd15;
      bus.b     = 3'd5;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy cycle %0d got %b want 0", i, bus.busy);
         end
         checks++;
         if (bus.done !== 1'b0) begin
            errors++;
            $display("FAIL reset_done cycle %0d got %b want 0", i, bus.done);
         end
         checks++;
         if (bus.product !== 7'd0) begin
            errors++;
            $display("FAIL reset_product cycle %0d got %0d want 0", i, bus.product);
         end
      end
      bus.start = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_single();
      bus.a     = 4'd15;
      bus.b     = 3'd5;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL single_run cycle %0d got busy=%b done=%b want busy=1 done=0",
                     i, bus.busy, bus.done);
         end
         @(negedge clk);
      end
      checks++;
      if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL single_done got busy=%b done=%b want busy=0 done=1", bus.busy, bus.done);
      end
      checks++;
      if (bus.product !== 7'd75) begin
         errors++;
         $display("FAIL single_product got %0d want 75", bus.product);
      end
      @(negedge clk);
      checks++;
      if (bus.done !== 1'b0 || bus.product !== 7'd75) begin
         errors++;
         $display("FAIL single_hold got done=%b product=%0d want done=0 product=75",
                  bus.done, bus.product);
      end
   endtask

   task automatic test_exhaustive();
      logic [6:0] expected;
      int cyc;
      bus.a     = 4'd0;
      bus.b     = 3'd0;
      bus.start = 1'b1;
      expected  = 7'd0;
      for (int k = 0; k < 128; k++) begin
         cyc = 0;
         do begin
            @(negedge clk);
            cyc++;
         end while (bus.done !== 1'b1 && cyc < 12);
         checks++;
         if (cyc != 4) begin
            errors++;
            $display("FAIL exh_spacing op %0d got %0d cycles want 4", k, cyc);
         end
         checks++;
         if (bus.product !== expected) begin
            errors++;
            $display("FAIL exh_product op %0d a=%0d b=%0d got %0d want %0d",
                     k, bus.a, bus.b, bus.product, expected);
         end
         if (k < 127) begin
            bus.a    = 4'((k + 1) >> 3);
            bus.b    = 3'((k + 1) & 7);
            expected = 7'(bus.a) * 7'(bus.b);
         end else begin
            bus.start = 1'b0;
         end
      end
      @(negedge clk);
   endtask

   task automatic test_start_while_busy();
      int         done_count;
      logic [6:0] captured;
      done_count = 0;
      captured   = '0;
      bus.a      = 4'd3;
      bus.b      = 3'd7;
      bus.start  = 1'b1;
      @(negedge clk);
      bus.a     = 4'd9;
      bus.b     = 3'd2;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (bus.done === 1'b1) begin
            done_count++;
            captured = bus.product;
         end
      end
      checks++;
      if (done_count != 1) begin
         errors++;
         $display("FAIL busy_done_count got %0d want 1", done_count);
      end
      checks++;
      if (captured !== 7'd21) begin
         errors++;
         $display("FAIL busy_product got %0d want 21", captured);
      end
      checks++;
      if (bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL busy_idle_after got busy=%b want 0", bus.busy);
      end
   endtask

   task automatic test_reset_mid_op();
      int done_count;
      int cyc;
      done_count = 0;
      bus.a      = 4'd12;
      bus.b      = 3'd6;
      bus.start  = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.product !== 7'd0) begin
         errors++;
         $display("FAIL abort_state got busy=%b done=%b product=%0d want 0 0 0",
                  bus.busy, bus.done, bus.product);
      end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (bus.done === 1'b1) done_count++;
      end
      checks++;
      if (done_count != 0 || bus.product !== 7'd0) begin
         errors++;
         $display("FAIL abort_no_done got dones=%0d product=%0d want 0 0",
                  done_count, bus.product);
      end
      bus.a     = 4'd5;
      bus.b     = 3'd5;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      cyc = 1;
      while (bus.done !== 1'b1 && cyc < 12) begin
         @(negedge clk);
         cyc++;
      end
      checks++;
      if (cyc != 4) begin
         errors++;
         $display("FAIL abort_next_latency got %0d cycles want 4", cyc);
      end
      checks++;
      if (bus.product !== 7'd25) begin
         errors++;
         $display("FAIL abort_next_product got %0d want 25", bus.product);
      end
      @(negedge clk);
   endtask

   task automatic test_wide();
      int cyc;
      wbus.a     = 8'd255;
      wbus.b     = 8'd255;
      wbus.start = 1'b1;
      @(negedge clk);
      wbus.start = 1'b0;
      cyc = 1;
      while (wbus.done !== 1'b1 && cyc < 20) begin
         checks++;
         if (wbus.busy !== 1'b1) begin
            errors++;
            $display("FAIL wide_busy cycle %0d got %b want 1", cyc, wbus.busy);
         end
         @(negedge clk);
         cyc++;
      end
      checks++;
      if (cyc != 9) begin
         errors++;
         $display("FAIL wide_latency got %0d cycles want 9", cyc);
      end
      checks++;
      if (wbus.product !== 16'd65025) begin
         errors++;
         $display("FAIL wide_product got %0d want 65025", wbus.product);
      end
      @(negedge clk);
   endtask

   initial begin
      checks     = 0;
      errors     = 0;
      rst_n      = 1'b0;
      bus.start  = 1'b0;
      bus.a      = '0;
      bus.b      = '0;
      wbus.start = 1'b0;
      wbus.a     = '0;
      wbus.b     = '0;
      test_reset();
      test_single();
      test_exhaustive();
      test_start_while_busy();
      test_reset_mid_op();
      test_wide();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
